// File: rtl/lcd_pkg.sv
// lcd_pkg: definitions shared by the LCD cell painter and the upstream grid
// scanner. It holds the object codes, their RGB565 colours, the ILI9341 opcodes
// used here, the grid geometry and the fixed panel-init byte table.
package lcd_pkg;

    typedef enum logic [2:0] {
        EMPTY  = 3'd0,
        BORDER = 3'd1,
        HEAD   = 3'd2,
        BODY   = 3'd3,
        APPLE  = 3'd4
    } obj_code_t;

    localparam logic [15:0] RGB_EMPTY  = 16'h0000;
    localparam logic [15:0] RGB_BORDER = 16'h7BEF;
    localparam logic [15:0] RGB_HEAD   = 16'h07E0;
    localparam logic [15:0] RGB_BODY   = 16'h03E0;
    localparam logic [15:0] RGB_APPLE  = 16'hF800;

    localparam logic [7:0] OP_SWRESET = 8'h01;
    localparam logic [7:0] OP_SLPOUT  = 8'h11;
    localparam logic [7:0] OP_COLMOD  = 8'h3A;
    localparam logic [7:0] OP_MADCTL  = 8'h36;
    localparam logic [7:0] OP_DISPON  = 8'h29;
    localparam logic [7:0] OP_CASET   = 8'h2A;
    localparam logic [7:0] OP_PASET   = 8'h2B;
    localparam logic [7:0] OP_RAMWR   = 8'h2C;

    // Parameter bytes for COLMOD (16 bpp) and MADCTL (landscape orientation)
    localparam logic [7:0] COLMOD_RGB565    = 8'h55;
    localparam logic [7:0] MADCTL_LANDSCAPE = 8'h28;

    localparam int GRID_COLS   = 16;
    localparam int GRID_ROWS   = 12;
    localparam int CELL_PX_DEF = 20;
    localparam int INIT_LEN    = 7;

    // Codes 5..7 have no object and paint as background
    function automatic logic [15:0] obj_colour(input logic [2:0] code);
        logic [15:0] c;
        case (code)
            BORDER:  c = RGB_BORDER;
            HEAD:    c = RGB_HEAD;
            BODY:    c = RGB_BODY;
            APPLE:   c = RGB_APPLE;
            default: c = RGB_EMPTY;
        endcase
        return c;
    endfunction

    // Init table entry as {dcx, byte}
    function automatic logic [8:0] init_word(input logic [2:0] idx);
        logic [8:0] w;
        case (idx)
            3'd0:    w = {1'b0, OP_SWRESET};
            3'd1:    w = {1'b0, OP_SLPOUT};
            3'd2:    w = {1'b0, OP_COLMOD};
            3'd3:    w = {1'b1, COLMOD_RGB565};
            3'd4:    w = {1'b0, OP_MADCTL};
            3'd5:    w = {1'b1, MADCTL_LANDSCAPE};
            default: w = {1'b0, OP_DISPON};
        endcase
        return w;
    endfunction

endpackage

// File: rtl/lcd_byte_writer.sv
// lcd_byte_writer: drives one byte onto the 8080 write-only bus per request.
//   start     - load byte_val/dc and begin a write (phase 0 on the next cycle)
//   byte_val  - byte to put on lcd_d
//   dc        - value for lcd_dcx (0 command, 1 data)
//   byte_done - high during phase 1; a start in that cycle chains the next
//               byte with no gap and keeps chip select low
//   lcd_*     - registered bus outputs
module lcd_byte_writer (
    input  logic       clk,
    input  logic       nrst,
    input  logic       start,
    input  logic [7:0] byte_val,
    input  logic       dc,
    output logic       byte_done,
    output logic [7:0] lcd_d,
    output logic       lcd_dcx,
    output logic       lcd_wr_n,
    output logic       lcd_cs_n
);
    logic phase1;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            lcd_d    <= '0;
            lcd_dcx  <= 1'b1;
            lcd_wr_n <= 1'b1;
            lcd_cs_n <= 1'b1;
            phase1   <= 1'b0;
        end else if (start) begin
            lcd_d    <= byte_val;
            lcd_dcx  <= dc;
            lcd_wr_n <= 1'b0;
            lcd_cs_n <= 1'b0;
            phase1   <= 1'b0;
        end else if (!lcd_wr_n) begin
            lcd_wr_n <= 1'b1;
            phase1   <= 1'b1;
        end else if (phase1) begin
            // No follow-on byte: burst ends here
            phase1   <= 1'b0;
            lcd_cs_n <= 1'b1;
        end
    end

    assign byte_done = phase1;

endmodule

// File: rtl/lcd_cell_painter.sv
// lcd_cell_painter: runs the panel init sequence, then fills the 20x20 pixel
// window of each accepted grid cell with the colour of its object.
//   clk, nrst            - clock, async active-low reset
//   diff, x, y, obj_code - changed-cell request (sampled in IDLE only)
//   cmd_done             - one-cycle pulse when the cell is finished
//   ready                - init complete
//   busy                 - request in progress (PAINT or DONE)
//   lcd_d/dcx/wr_n/cs_n  - 8080 write bus; lcd_rd_n tied high
module lcd_cell_painter
    import lcd_pkg::*;
#(
    parameter int CELL_PX     = 20,
    parameter int WAIT_CYCLES = 600000
) (
    input  logic       clk,
    input  logic       nrst,
    input  logic       diff,
    input  logic [3:0] x,
    input  logic [3:0] y,
    input  logic [2:0] obj_code,
    output logic       cmd_done,
    output logic       ready,
    output logic       busy,
    output logic [7:0] lcd_d,
    output logic       lcd_dcx,
    output logic       lcd_wr_n,
    output logic       lcd_cs_n,
    output logic       lcd_rd_n
);
    localparam logic [2:0] S_INIT_BYTE = 3'd0;
    localparam logic [2:0] S_INIT_WAIT = 3'd1;
    localparam logic [2:0] S_IDLE      = 3'd2;
    localparam logic [2:0] S_PAINT     = 3'd3;
    localparam logic [2:0] S_DONE      = 3'd4;
    localparam logic [2:0] S_GAP       = 3'd5;

    // 11 header bytes followed by two bytes per pixel
    localparam logic [9:0] LAST_IDX = 10'(11 + 2 * CELL_PX * CELL_PX - 1);

    logic [2:0]  state;
    logic [2:0]  init_idx;
    logic        issued;
    logic [19:0] wait_cnt;
    logic        gap_cnt;
    logic [9:0]  idx;
    logic [3:0]  x_r;
    logic [3:0]  y_r;
    logic [2:0]  obj_r;

    logic        wr_start;
    logic [7:0]  wr_byte;
    logic        wr_dc;
    logic        byte_done;

    logic [8:0]  x0, x1, y0, y1;
    logic [15:0] colour;
    logic [9:0]  nidx;
    logic [8:0]  paint_w;
    logic [8:0]  init_w;

    assign x0     = 9'(x_r) * 9'(CELL_PX);
    assign x1     = x0 + 9'(CELL_PX - 1);
    assign y0     = 9'(y_r) * 9'(CELL_PX);
    assign y1     = y0 + 9'(CELL_PX - 1);
    assign colour = obj_colour(obj_r);
    assign nidx   = idx + 10'd1;
    assign init_w = init_word(issued ? 3'(init_idx + 3'd1) : init_idx);

    // {dcx, byte} for the paint byte that follows the one in flight.
    // Pixel bytes start at odd index 11, so an odd index is a high byte.
    always_comb begin
        paint_w = {1'b0, OP_CASET};
        if (nidx < 10'd11) begin
            case (nidx[3:0])
                4'd1:    paint_w = {1'b1, 7'b0, x0[8]};
                4'd2:    paint_w = {1'b1, x0[7:0]};
                4'd3:    paint_w = {1'b1, 7'b0, x1[8]};
                4'd4:    paint_w = {1'b1, x1[7:0]};
                4'd5:    paint_w = {1'b0, OP_PASET};
                4'd6:    paint_w = {1'b1, 7'b0, y0[8]};
                4'd7:    paint_w = {1'b1, y0[7:0]};
                4'd8:    paint_w = {1'b1, 7'b0, y1[8]};
                4'd9:    paint_w = {1'b1, y1[7:0]};
                4'd10:   paint_w = {1'b0, OP_RAMWR};
                default: paint_w = {1'b0, OP_CASET};
            endcase
        end else begin
            paint_w = {1'b1, nidx[0] ? colour[15:8] : colour[7:0]};
        end
    end

    // Next byte is issued in the phase-1 cycle of the current one so bursts
    // run back to back; the first byte of a cell issues on the acceptance edge.
    always_comb begin
        wr_start = 1'b0;
        wr_byte  = '0;
        wr_dc    = 1'b1;
        case (state)
            S_INIT_BYTE: begin
                if (!issued || (byte_done && init_idx != 3'd0 &&
                                init_idx != 3'd1 && init_idx != 3'(INIT_LEN - 1))) begin
                    wr_start = 1'b1;
                    {wr_dc, wr_byte} = init_w;
                end
            end
            S_IDLE: begin
                if (diff && (y < 4'(GRID_ROWS))) begin
                    wr_start = 1'b1;
                    wr_dc    = 1'b0;
                    wr_byte  = OP_CASET;
                end
            end
            S_PAINT: begin
                if (byte_done && idx != LAST_IDX) begin
                    wr_start = 1'b1;
                    {wr_dc, wr_byte} = paint_w;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state    <= S_INIT_BYTE;
            init_idx <= '0;
            issued   <= 1'b0;
            wait_cnt <= '0;
            gap_cnt  <= 1'b0;
            idx      <= '0;
            x_r      <= '0;
            y_r      <= '0;
            obj_r    <= '0;
        end else begin
            case (state)
                S_INIT_BYTE: begin
                    if (!issued) begin
                        issued <= 1'b1;
                    end else if (byte_done) begin
                        if (init_idx == 3'd0 || init_idx == 3'd1) begin
                            state    <= S_INIT_WAIT;
                            issued   <= 1'b0;
                            wait_cnt <= '0;
                            init_idx <= init_idx + 3'd1;
                        end else if (init_idx == 3'(INIT_LEN - 1)) begin
                            state <= S_IDLE;
                        end else begin
                            init_idx <= init_idx + 3'd1;
                        end
                    end
                end
                S_INIT_WAIT: begin
                    if (wait_cnt == 20'(WAIT_CYCLES - 1)) begin
                        state <= S_INIT_BYTE;
                    end else begin
                        wait_cnt <= wait_cnt + 20'd1;
                    end
                end
                S_IDLE: begin
                    if (diff) begin
                        x_r   <= x;
                        y_r   <= y;
                        obj_r <= obj_code;
                        idx   <= '0;
                        state <= (y < 4'(GRID_ROWS)) ? S_PAINT : S_DONE;
                    end
                end
                S_PAINT: begin
                    if (byte_done) begin
                        if (idx == LAST_IDX) begin
                            state <= S_DONE;
                        end else begin
                            idx <= nidx;
                        end
                    end
                end
                S_DONE: begin
                    state   <= S_GAP;
                    gap_cnt <= 1'b0;
                end
                S_GAP: begin
                    if (gap_cnt) begin
                        state <= S_IDLE;
                    end else begin
                        gap_cnt <= 1'b1;
                    end
                end
                default: state <= S_INIT_BYTE;
            endcase
        end
    end

    assign cmd_done = (state == S_DONE);
    assign busy     = (state == S_PAINT) || (state == S_DONE);
    assign ready    = (state != S_INIT_BYTE) && (state != S_INIT_WAIT);
    assign lcd_rd_n = 1'b1;

    lcd_byte_writer u_writer (
        .clk       (clk),
        .nrst      (nrst),
        .start     (wr_start),
        .byte_val  (wr_byte),
        .dc        (wr_dc),
        .byte_done (byte_done),
        .lcd_d     (lcd_d),
        .lcd_dcx   (lcd_dcx),
        .lcd_wr_n  (lcd_wr_n),
        .lcd_cs_n  (lcd_cs_n)
    );

endmodule

// File: tb/tb_lcd_cell_painter.sv
// tb_lcd_cell_painter: self-checking bench for lcd_cell_painter.
// The bench builds the expected bus stream ({dcx, byte} per write) from the
// panel protocol rules and checks every write strobe against it, plus
// per-scenario timing of cmd_done/busy and a few literal byte expectations.
module tb_lcd_cell_painter;

    logic       tb_clk;
    logic       nrst;
    logic       diff;
    logic [3:0] x;
    logic [3:0] y;
    logic [2:0] obj_code;
    logic       cmd_done, ready, busy;
    logic [7:0] lcd_d;
    logic       lcd_dcx, lcd_wr_n, lcd_cs_n, lcd_rd_n;

    int checks = 0;
    int errors = 0;

    logic [8:0] exp_q[$];
    logic [7:0] obs [0:8191];
    int         obs_n = 0;
    logic       prev_low = 1'b0;

    lcd_cell_painter #(.CELL_PX(20), .WAIT_CYCLES(8)) dut (
        .clk      (tb_clk),
        .nrst     (nrst),
        .diff     (diff),
        .x        (x),
        .y        (y),
        .obj_code (obj_code),
        .cmd_done (cmd_done),
        .ready    (ready),
        .busy     (busy),
        .lcd_d    (lcd_d),
        .lcd_dcx  (lcd_dcx),
        .lcd_wr_n (lcd_wr_n),
        .lcd_cs_n (lcd_cs_n),
        .lcd_rd_n (lcd_rd_n)
    );

    initial tb_clk = 1'b0;
    always #5 tb_clk = ~tb_clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    function automatic logic [15:0] model_colour(input logic [2:0] c);
        case (c)
            3'd1:    return 16'h7BEF;
            3'd2:    return 16'h07E0;
            3'd3:    return 16'h03E0;
            3'd4:    return 16'hF800;
            default: return 16'h0000;
        endcase
    endfunction

    task automatic push_init();
        exp_q.push_back({1'b0, 8'h01});
        exp_q.push_back({1'b0, 8'h11});
        exp_q.push_back({1'b0, 8'h3A});
        exp_q.push_back({1'b1, 8'h55});
        exp_q.push_back({1'b0, 8'h36});
        exp_q.push_back({1'b1, 8'h28});
        exp_q.push_back({1'b0, 8'h29});
    endtask

    // Expected window fill for a cell; only the first nbytes are queued
    task automatic push_paint(input int cx, input int cy, input logic [2:0] c, input int nbytes);
        logic [8:0]  s[$];
        int          x0, y0;
        logic [15:0] col;
        logic [15:0] v;
        x0  = cx * 20;
        y0  = cy * 20;
        col = model_colour(c);
        s.push_back({1'b0, 8'h2A});
        v = 16'(x0);      s.push_back({1'b1, v[15:8]}); s.push_back({1'b1, v[7:0]});
        v = 16'(x0 + 19); s.push_back({1'b1, v[15:8]}); s.push_back({1'b1, v[7:0]});
        s.push_back({1'b0, 8'h2B});
        v = 16'(y0);      s.push_back({1'b1, v[15:8]}); s.push_back({1'b1, v[7:0]});
        v = 16'(y0 + 19); s.push_back({1'b1, v[15:8]}); s.push_back({1'b1, v[7:0]});
        s.push_back({1'b0, 8'h2C});
        for (int p = 0; p < 400; p++) begin
            s.push_back({1'b1, col[15:8]});
            s.push_back({1'b1, col[7:0]});
        end
        for (int i = 0; i < nbytes && i < s.size(); i++) exp_q.push_back(s[i]);
    endtask

    // Bus compare: each cycle with the strobe low is one latched byte
    always @(negedge tb_clk) begin
        if (nrst === 1'b1) begin
            chk("rd_n_high", {31'b0, lcd_rd_n}, 32'd1);
            if (lcd_wr_n === 1'b0) begin
                chk("wr_low_one_cycle", {31'b0, prev_low}, 32'd0);
                chk("cs_low_in_write", {31'b0, lcd_cs_n}, 32'd0);
                if (exp_q.size() == 0) begin
                    chk("unexpected_write", {23'b0, lcd_dcx, lcd_d}, 32'h1ff);
                end else begin
                    chk("bus_word", {23'b0, lcd_dcx, lcd_d}, {23'b0, exp_q.pop_front()});
                end
                if (obs_n < 8192) obs[obs_n] = lcd_d;
                obs_n++;
            end
        end
        prev_low = (lcd_wr_n === 1'b0);
    end

    task automatic check_reset_vals();
        chk("rst_lcd_d", {24'b0, lcd_d}, 32'h00);
        chk("rst_dcx", {31'b0, lcd_dcx}, 32'd1);
        chk("rst_wr_n", {31'b0, lcd_wr_n}, 32'd1);
        chk("rst_cs_n", {31'b0, lcd_cs_n}, 32'd1);
        chk("rst_rd_n", {31'b0, lcd_rd_n}, 32'd1);
        chk("rst_cmd_done", {31'b0, cmd_done}, 32'd0);
        chk("rst_ready", {31'b0, ready}, 32'd0);
        chk("rst_busy", {31'b0, busy}, 32'd0);
    endtask

    // Release reset with diff held high and follow the init sequence
    task automatic run_init();
        int tw[8];
        int nw = 0;
        int ndone = 0;
        int rdy_off = -1;
        push_init();
        diff = 1'b1;
        @(negedge tb_clk);
        nrst = 1'b1;
        for (int off = 0; off < 600 && rdy_off < 0; off++) begin
            @(negedge tb_clk);
            if (cmd_done === 1'b1) ndone++;
            if (lcd_wr_n === 1'b0) begin
                if (nw < 8) tw[nw] = off;
                nw++;
                if (nw == 7) begin
                    diff = 1'b0;
                    chk("ready_before_last", {31'b0, ready}, 32'd0);
                end
            end
            if (ready === 1'b1) rdy_off = off;
        end
        chk("init_writes", 32'(nw), 32'd7);
        chk("init_no_cmd_done", 32'(ndone), 32'd0);
        if (nw >= 7) begin
            chk("init_wait_after_swreset", {31'b0, (tw[1] - tw[0]) >= 10}, 32'd1);
            chk("init_wait_after_slpout", {31'b0, (tw[2] - tw[1]) >= 10}, 32'd1);
            chk("ready_rise_offset", 32'(rdy_off - tw[6]), 32'd2);
        end
        repeat (3) @(negedge tb_clk);
    endtask

    task automatic do_paint(input logic [3:0] px, input logic [3:0] py, input logic [2:0] pobj,
                            input int exp_off, output int base);
        int first = -1;
        int cnt = 0;
        if (py < 4'd12) push_paint(px, py, pobj, 811);
        base = obs_n;
        @(negedge tb_clk);
        diff = 1'b1; x = px; y = py; obj_code = pobj;
        @(posedge tb_clk);
        for (int off = 0; off <= exp_off + 8; off++) begin
            @(negedge tb_clk);
            if (off == 0) begin
                diff = 1'b0;
                chk("busy_at_accept", {31'b0, busy}, 32'd1);
            end
            if (cmd_done === 1'b1) begin
                if (first < 0) first = off;
                cnt++;
            end
            if (off == exp_off) chk("busy_in_done", {31'b0, busy}, 32'd1);
            if (off == exp_off + 1) begin
                chk("busy_in_gap", {31'b0, busy}, 32'd0);
                chk("cs_high_after_done", {31'b0, lcd_cs_n}, 32'd1);
                chk("ready_held", {31'b0, ready}, 32'd1);
            end
        end
        chk("done_offset", 32'(first), 32'(exp_off));
        chk("done_width", 32'(cnt), 32'd1);
        chk("paint_byte_count", 32'(obs_n - base), (py < 4'd12) ? 32'd811 : 32'd0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int dn[2];
        int nd;
        logic [7:0] lit_hd [13];
        logic [7:0] got;

        nrst = 1'b0; diff = 1'b0; x = '0; y = '0; obj_code = '0;
        repeat (3) @(negedge tb_clk);
        check_reset_vals();

        // Init with diff asserted throughout
        run_init();
        chk("queue_after_init", 32'(exp_q.size()), 32'd0);

        // Main paint plus literal pins of the header and first pixel
        do_paint(4'd4, 4'd4, 3'd2, 1622, base);
        lit_hd = '{8'h2A, 8'h00, 8'h50, 8'h00, 8'h63, 8'h2B, 8'h00, 8'h50,
                   8'h00, 8'h63, 8'h2C, 8'h07, 8'hE0};
        for (int i = 0; i < 13; i++) begin
            got = obs[base + i];
            chk("head_cell_literal", {24'b0, got}, {24'b0, lit_hd[i]});
        end

        // Bottom-right corner: 9-bit coordinates above 255
        do_paint(4'd15, 4'd11, 3'd1, 1622, base);
        got = obs[base + 1];  chk("corner_x0h", {24'b0, got}, 32'h01);
        got = obs[base + 2];  chk("corner_x0l", {24'b0, got}, 32'h2C);
        got = obs[base + 3];  chk("corner_x1h", {24'b0, got}, 32'h01);
        got = obs[base + 4];  chk("corner_x1l", {24'b0, got}, 32'h3F);
        got = obs[base + 6];  chk("corner_y0h", {24'b0, got}, 32'h00);
        got = obs[base + 7];  chk("corner_y0l", {24'b0, got}, 32'hDC);
        got = obs[base + 8];  chk("corner_y1h", {24'b0, got}, 32'h00);
        got = obs[base + 9];  chk("corner_y1l", {24'b0, got}, 32'hEF);
        got = obs[base + 11]; chk("corner_px_hi", {24'b0, got}, 32'h7B);
        got = obs[base + 12]; chk("corner_px_lo", {24'b0, got}, 32'hEF);

        // Row 12 is off-grid: no writes, immediate cmd_done
        do_paint(4'd3, 4'd12, 3'd4, 0, base);

        // diff held high across two requests; obj_code changes mid-paint
        push_paint(2, 3, 3'd3, 811);
        push_paint(2, 3, 3'd4, 811);
        nd = 0; dn[0] = -1; dn[1] = -1;
        @(negedge tb_clk);
        diff = 1'b1; x = 4'd2; y = 4'd3; obj_code = 3'd3;
        @(posedge tb_clk);
        for (int off = 0; off <= 3256; off++) begin
            @(negedge tb_clk);
            if (off == 300) obj_code = 3'd4;
            if (off == 1627) diff = 1'b0;
            if (cmd_done === 1'b1) begin
                if (nd < 2) dn[nd] = off;
                nd++;
            end
            if (off >= 1623 && off <= 1625) chk("no_retrigger_in_gap", {31'b0, busy}, 32'd0);
            if (off == 1625) chk("idle_before_next", {31'b0, lcd_wr_n}, 32'd1);
            if (off == 1626) begin
                chk("next_accept_wr", {31'b0, lcd_wr_n}, 32'd0);
                chk("next_accept_busy", {31'b0, busy}, 32'd1);
            end
        end
        chk("hs_done_count", 32'(nd), 32'd2);
        chk("hs_done_first", 32'(dn[0]), 32'd1622);
        chk("hs_done_second", 32'(dn[1]), 32'd3248);
        repeat (4) @(negedge tb_clk);

        // Reset in the middle of a paint, after byte 299 has been latched
        push_paint(1, 2, 3'd3, 300);
        nd = 0;
        @(negedge tb_clk);
        diff = 1'b1; x = 4'd1; y = 4'd2; obj_code = 3'd3;
        @(posedge tb_clk);
        for (int off = 0; off < 600; off++) begin
            @(negedge tb_clk);
            if (off == 0) diff = 1'b0;
            if (cmd_done === 1'b1) nd++;
        end
        #1 nrst = 1'b0;
        #1 check_reset_vals();
        chk("mid_paint_bytes_seen", 32'(exp_q.size()), 32'd0);
        repeat (3) begin
            @(negedge tb_clk);
            if (cmd_done === 1'b1) nd++;
        end
        chk("no_done_for_aborted", 32'(nd), 32'd0);
        run_init();

        // Recovery after re-init
        do_paint(4'd0, 4'd0, 3'd0, 1622, base);

        repeat (4) @(negedge tb_clk);
        chk("exp_queue_drained", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
